// File: rtl/alu_pkg.sv
// Shared op-code constants and small helpers for the decimal-capable ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBC = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_SR  = 4'd5;

  localparam logic [4:0] BCD_DIGIT_MAX = 5'd9;
  localparam logic [3:0] BCD_FIX       = 4'd6;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/bcd_adjust.sv
// Per-nibble decimal adjust; each nibble wraps modulo 16 with no inter-nibble carry.
module bcd_adjust
  import alu_pkg::*;
(
  input  logic [7:0] adj_in,
  input  logic       dec_add,
  input  logic       dec_sub,
  input  logic       half_carry,
  input  logic       carry,
  output logic [7:0] adj_out
);

  logic [3:0] lo_s;
  logic [3:0] hi_s;

  // Add takes priority when both modes are requested.
  always_comb begin
    lo_s = adj_in[3:0];
    hi_s = adj_in[7:4];
    if (dec_add) begin
      lo_s = half_carry ? (adj_in[3:0] + BCD_FIX) : adj_in[3:0];
      hi_s = carry      ? (adj_in[7:4] + BCD_FIX) : adj_in[7:4];
    end else if (dec_sub) begin
      lo_s = half_carry ? adj_in[3:0] : (adj_in[3:0] - BCD_FIX);
      hi_s = carry      ? adj_in[7:4] : (adj_in[7:4] - BCD_FIX);
    end else begin
      lo_s = adj_in[3:0];
      hi_s = adj_in[7:4];
    end
  end

  assign adj_out = {hi_s, lo_s};

endmodule

// File: rtl/alu_decimal_unit.sv
// Operand registers, combinational binary/BCD ALU and decimal adjuster.
module alu_decimal_unit
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       a_load,
  input  logic       a_src,
  input  logic [7:0] a_in,
  input  logic [2:0] ir_bits,
  input  logic       b_load,
  input  logic [7:0] b_in,
  input  logic       c_in,
  input  logic [3:0] alu_op,
  input  logic       dec_add,
  input  logic       dec_sub,
  input  logic [7:0] adj_in,
  output logic [7:0] alu_out,
  output logic       carry_out,
  output logic       half_carry_out,
  output logic       overflow_out,
  output logic       carry_last,
  output logic [7:0] alua_q,
  output logic [7:0] adj_out
);

  logic [7:0] alua_r;
  logic [7:0] alub_r;
  logic       carry_last_r;

  logic [8:0] sum_s;
  logic [4:0] lo_s;
  logic [4:0] hi_s;
  logic [7:0] result_s;
  logic       carry_s;
  logic       half_s;
  logic       overflow_s;

  // Operand A: direct data or a one-hot bit mask selected by ir_bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alua_r <= 8'h00;
    end else if (a_load) begin
      alua_r <= a_src ? onehot8(ir_bits) : a_in;
    end
  end

  // Operand B register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alub_r <= 8'h00;
    end else if (b_load) begin
      alub_r <= b_in;
    end
  end

  // Carry history, sampled every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_last_r <= 1'b0;
    end else begin
      carry_last_r <= carry_s;
    end
  end

  // ALU datapath; SBC relies on the caller pre-inverting B.
  always_comb begin
    sum_s      = {1'b0, alua_r} + {1'b0, alub_r} + {8'h00, c_in};
    lo_s       = {1'b0, alua_r[3:0]} + {1'b0, alub_r[3:0]} + {4'h0, c_in};
    hi_s       = 5'd0;
    result_s   = 8'h00;
    carry_s    = 1'b0;
    half_s     = 1'b0;
    overflow_s = 1'b0;
    case (alu_op)
      OP_ADC, OP_SBC: begin
        if (dec_add) begin
          half_s     = (lo_s > BCD_DIGIT_MAX);
          hi_s       = {1'b0, alua_r[7:4]} + {1'b0, alub_r[7:4]} + {4'h0, half_s};
          carry_s    = (hi_s > BCD_DIGIT_MAX);
          result_s   = {hi_s[3:0], lo_s[3:0]};
          overflow_s = ~(alua_r[7] ^ alub_r[7]) & (alua_r[7] ^ hi_s[3]);
        end else begin
          half_s     = lo_s[4];
          carry_s    = sum_s[8];
          result_s   = sum_s[7:0];
          overflow_s = ~(alua_r[7] ^ alub_r[7]) & (alua_r[7] ^ sum_s[7]);
        end
      end
      OP_AND: result_s = alua_r & alub_r;
      OP_OR:  result_s = alua_r | alub_r;
      OP_EOR: result_s = alua_r ^ alub_r;
      OP_SR: begin
        result_s = {c_in, alua_r[7:1]};
        carry_s  = alua_r[0];
      end
      default: begin
        result_s   = 8'h00;
        carry_s    = 1'b0;
        half_s     = 1'b0;
        overflow_s = 1'b0;
      end
    endcase
  end

  bcd_adjust u_bcd_adjust (
    .adj_in     (adj_in),
    .dec_add    (dec_add),
    .dec_sub    (dec_sub),
    .half_carry (half_s),
    .carry      (carry_s),
    .adj_out    (adj_out)
  );

  assign alu_out        = result_s;
  assign carry_out      = carry_s;
  assign half_carry_out = half_s;
  assign overflow_out   = overflow_s;
  assign carry_last     = carry_last_r;
  assign alua_q         = alua_r;

endmodule

// File: tb/tb_alu_decimal_unit.sv
// Directed and randomized checks of alu_decimal_unit with an expectation queue.
module tb_alu_decimal_unit;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_load, a_src, b_load, c_in, dec_add, dec_sub;
  logic [7:0] a_in, b_in, adj_in;
  logic [2:0] ir_bits;
  logic [3:0] alu_op;
  logic [7:0] alu_out, alua_q, adj_out;
  logic       carry_out, half_carry_out, overflow_out, carry_last;

  typedef struct {
    string      tag;
    logic [7:0] alu;
    logic       c;
    logic       h;
    logic       v;
    logic [7:0] adj;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  alu_decimal_unit dut (
    .clk(clk), .reset(reset), .a_load(a_load), .a_src(a_src), .a_in(a_in),
    .ir_bits(ir_bits), .b_load(b_load), .b_in(b_in), .c_in(c_in),
    .alu_op(alu_op), .dec_add(dec_add), .dec_sub(dec_sub), .adj_in(adj_in),
    .alu_out(alu_out), .carry_out(carry_out), .half_carry_out(half_carry_out),
    .overflow_out(overflow_out), .carry_last(carry_last), .alua_q(alua_q),
    .adj_out(adj_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] alu, input logic c, input logic h,
                              input logic v, input logic [7:0] adj);
    exp_t e;
    e.tag = ""; e.alu = alu; e.c = c; e.h = h; e.v = v; e.adj = adj;
    return e;
  endfunction

  // Reference behaviour written from the operation definitions.
  function automatic exp_t model(input int a, input int b, input int c, input int op,
                                 input int da, input int ds, input int adj);
    exp_t e;
    int s, lo, hi, alo, ahi;
    e = mk(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    if (op == 0 || op == 1) begin
      if (da != 0) begin
        lo = (a % 16) + (b % 16) + c;
        e.h = (lo > 9);
        hi = (a / 16) + (b / 16) + (e.h ? 1 : 0);
        e.c = (hi > 9);
        e.alu = 8'(((hi % 16) * 16) + (lo % 16));
        e.v = ((a / 128) == (b / 128)) && (((hi / 8) % 2) != (a / 128));
      end else begin
        s = a + b + c;
        e.alu = 8'(s % 256);
        e.c = (s > 255);
        e.h = ((a % 16) + (b % 16) + c) > 15;
        e.v = ((a / 128) == (b / 128)) && (((s / 128) % 2) != (a / 128));
      end
    end else if (op == 2) e.alu = 8'(a) & 8'(b);
    else if (op == 3) e.alu = 8'(a) | 8'(b);
    else if (op == 4) e.alu = 8'(a) ^ 8'(b);
    else if (op == 5) begin
      e.alu = 8'((c * 128) + (a / 2));
      e.c = (a % 2) == 1;
    end
    alo = adj % 16;
    ahi = adj / 16;
    if (da != 0) begin
      if (e.h) alo = (alo + 6) % 16;
      if (e.c) ahi = (ahi + 6) % 16;
    end else if (ds != 0) begin
      if (!e.h) alo = (alo + 10) % 16;
      if (!e.c) ahi = (ahi + 10) % 16;
    end
    e.adj = 8'(ahi * 16 + alo);
    return e;
  endfunction

  task automatic load(input logic [7:0] av, input logic [7:0] bv);
    a_load = 1'b1; a_src = 1'b0; a_in = av; b_load = 1'b1; b_in = bv;
    @(posedge clk); #1;
    a_load = 1'b0; b_load = 1'b0;
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ".alu"}, alu_out, e.alu);
    chk({e.tag, ".c"},   {7'd0, carry_out}, {7'd0, e.c});
    chk({e.tag, ".h"},   {7'd0, half_carry_out}, {7'd0, e.h});
    chk({e.tag, ".v"},   {7'd0, overflow_out}, {7'd0, e.v});
    chk({e.tag, ".adj"}, adj_out, e.adj);
  endtask

  task automatic apply(input string tag, input logic [3:0] op, input logic c,
                       input logic da, input logic ds, input logic [7:0] adj,
                       input exp_t e);
    alu_op = op; c_in = c; dec_add = da; dec_sub = ds; adj_in = adj;
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    int ra, rb, rc, rop, rda, rds, radj;
    reset = 1'b1; a_load = 1'b0; a_src = 1'b0; a_in = 8'h00; ir_bits = 3'd0;
    b_load = 1'b0; b_in = 8'h00; c_in = 1'b0; alu_op = OP_ADC;
    dec_add = 1'b0; dec_sub = 1'b0; adj_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    apply("rst_adc", OP_ADC, 1'b0, 1'b0, 1'b0, 8'h00, mk(8'h00, 1'b0, 1'b0, 1'b0, 8'h00));
    chk("rst_alua", alua_q, 8'h00);
    chk("rst_clast", {7'd0, carry_last}, 8'h00);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    load(8'h50, 8'h50);
    apply("bin_50_50", OP_ADC, 1'b0, 1'b0, 1'b0, 8'h00, mk(8'hA0, 1'b0, 1'b0, 1'b1, 8'h00));
    @(posedge clk); #1;
    load(8'hFF, 8'h01);
    apply("bin_ff_01", OP_ADC, 1'b0, 1'b0, 1'b0, 8'h00, mk(8'h00, 1'b1, 1'b1, 1'b0, 8'h00));
    @(posedge clk); #1;
    load(8'h58, 8'h46);
    apply("bcd_58_46", OP_ADC, 1'b0, 1'b1, 1'b0, 8'hAE, mk(8'hAE, 1'b1, 1'b1, 1'b1, 8'h04));
    @(posedge clk); #1;
    load(8'h09, 8'h01);
    apply("bcd_09_01", OP_ADC, 1'b0, 1'b1, 1'b0, 8'h1A, mk(8'h1A, 1'b0, 1'b1, 1'b0, 8'h10));
    @(posedge clk); #1;
    load(8'h10, 8'hFE);
    apply("bcd_sub", OP_SBC, 1'b1, 1'b0, 1'b1, 8'h0F, mk(8'h0F, 1'b1, 1'b0, 1'b0, 8'h09));
    @(posedge clk); #1;
    load(8'h81, 8'h00);
    apply("sr_81", OP_SR, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'hC0, 1'b1, 1'b0, 1'b0, 8'h00));
    @(posedge clk); #1;
    chk("sr_clast", {7'd0, carry_last}, 8'h01);

    a_load = 1'b1; a_src = 1'b1; ir_bits = 3'd5; b_load = 1'b1; b_in = 8'h2F;
    @(posedge clk); #1;
    a_load = 1'b0; b_load = 1'b0; a_src = 1'b0;
    chk("onehot_alua", alua_q, 8'h20);
    apply("and_2f", OP_AND, 1'b0, 1'b0, 1'b0, 8'h00, mk(8'h20, 1'b0, 1'b0, 1'b0, 8'h00));
    #2 reset = 1'b1;
    #1 chk("rst_async_alua", alua_q, 8'h00);
    a_load = 1'b1; a_in = 8'h33;
    @(posedge clk); #1;
    chk("rst_hold_alua", alua_q, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;
    a_load = 1'b0;
    chk("rst_release_load", alua_q, 8'h33);

    load(8'h5A, 8'hC3);
    for (int k = 0; k < 3; k++) begin
      apply("reserved9", 4'd9, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h00, 1'b0, 1'b0, 1'b0, 8'h00));
      @(posedge clk); #1;
      chk("hold_alua", alua_q, 8'h5A);
    end
    apply("hold_b_eor", OP_EOR, 1'b0, 1'b0, 1'b0, 8'h00, mk(8'h99, 1'b0, 1'b0, 1'b0, 8'h00));
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      rc = int'($urandom_range(0, 1));
      rop = int'($urandom_range(0, 15));
      rda = int'($urandom_range(0, 1));
      rds = int'($urandom_range(0, 1));
      radj = int'($urandom_range(0, 255));
      load(8'(ra), 8'(rb));
      apply("rand", 4'(rop), rc[0], rda[0], rds[0], 8'(radj),
            model(ra, rb, rc, rop, rda, rds, radj));
      @(posedge clk); #1;
    end

    chk("sb_empty", 8'(sb.size()), 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
